myo_status_logger: RTL and testbench
====================================

Name: myo_status_logger

Overview:
- Downstream consumer of the myo control stage.
- Captures each per-motor status sample (position, velocity, current, displacement) latched after an SPI frame completes.
- Timestamps, sequence-numbers and buffers samples in a FIFO so the HPS can drain full-rate telemetry over the lightweight AXI/Avalon bridge without losing samples between polls.

Parameters:
- NUMBER_OF_MOTORS, 6, motors on the bus; sample_motor values >= this are ignored.
- FIFO_DEPTH, 64, entries; power of two, 4..1024.
- CLOCK_SPEED_HZ, 50_000_000, clock frequency; must be a multiple of 1_000_000.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle pulse: sample fields valid
- sample_motor  in  8  motor index of sample
- sample_position  in  32  signed motor position
- sample_velocity  in  16  signed velocity
- sample_current  in  16  signed current
- sample_displacement  in  16  spring displacement
- address  in  4  Avalon word address
- read  in  1  Avalon read
- write  in  1  Avalon write
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data
- waitrequest  out  1  Avalon wait
- irq  out  1  FIFO threshold interrupt (see Optional Feature)

Behaviour:
- Reset (reset_n low, async): FIFO empty, pointers 0, overflow_count 0, seq 0, timestamp 0, enable 0, motor_mask all ones, readdata 0, waitrequest 0, irq 0.
- Timestamp:
  - Prescaler counts 0..CLOCK_SPEED_HZ/1_000_000-1.
  - 32-bit µs counter increments on prescaler wrap; wraps 0xFFFFFFFF->0.
  - Runs regardless of enable.
- Entry is 128 bits: word0 timestamp; word1 position; word2 {velocity[31:16], current[15:0]}; word3 {displacement[31:16], motor[15:8], seq[7:0]}.
- Capture: sample_valid && enable && sample_motor<NUMBER_OF_MOTORS && motor_mask[sample_motor] is a "qualified sample".
  - Entry is written the cycle after sample_valid (1-cycle latency) using the timestamp value at sample_valid.
  - seq increments (8-bit wrap) on every qualified sample, including dropped ones, so the host sees gaps.
- Full: a qualified sample with FIFO full and no pop that cycle is dropped; overflow_count += 1, saturating at 0xFFFFFFFF.
  - Push and pop in the same cycle while full: both occur, no drop.
- Avalon read:
  - waitrequest is high on the first cycle of read and low on the second; readdata is registered and valid while waitrequest is low.
  - address 0..3: head entry word0..3.
    - Reading address 3 while not empty pops the entry on the completing cycle.
    - Reads of 0..3 while empty return 32'hDEADBEEF and do not pop.
  - address 4: fill level (zero-extended).
  - address 5: overflow_count.
  - address 6: {31'b0, enable}.
  - address 7: motor_mask (zero-extended).
  - address 8: irq_threshold.
  - Other addresses: 32'hDEADBEEF.
- Avalon write:
  - waitrequest stays low; takes effect at the clock edge.
  - address 6: bit0 -> enable; bit1=1 -> flush.
    - Flush empties the FIFO and clears overflow_count and seq.
    - A push or pop in the flush cycle is discarded.
  - address 7: motor_mask <= writedata[NUMBER_OF_MOTORS-1:0].
  - address 8: irq_threshold <= writedata[log2(FIFO_DEPTH):0].
  - Other addresses: ignored.
- Simultaneous read and write on the same cycle: undefined by the bus; the write takes priority and the read still completes.
- Disable mid-operation: buffered entries remain readable; new samples are ignored and seq holds.

Optional Feature:
- MYO_STATUS_LOGGER_IRQ_EN defined: irq is registered high whenever fill level >= irq_threshold and irq_threshold != 0.
  - Reading address 4 does not clear it; draining below threshold does.
- Undefined: irq tied 0, irq_threshold register absent, address 8 reads 32'hDEADBEEF and writes are ignored.

Test Plan:
- Reset, write 6<=1, pulse sample motor=2 pos=0x12345678 vel=-5 cur=300 disp=0x0040 -> fill=1; reads 1,2,3 return 0x12345678, 0xFFFB012C, 0x00400200; fill=0 after word3.
- Drive 70 qualified samples with FIFO_DEPTH=64 and no reads -> fill=64, overflow_count=6; the 64th drained entry has seq=63, and the next sample after draining has seq=70.
- motor_mask=0b000101, samples for motors 0..5 and motor 9 -> only motors 0 and 2 logged, fill=2, seq=2.
- FIFO full, pop of word3 in the same cycle as a sample_valid -> fill stays 64, overflow_count unchanged.
- Write 6<=3 with 10 entries and overflow 4 -> fill=0, overflow 0, enable=1; read 0 returns 0xDEADBEEF.
- IRQ_EN, threshold=8: push 8 -> irq=1; pop 1 -> irq=0; with the macro undefined, irq stays 0 throughout.

Source files
------------

// File: rtl/myo_status_logger.sv
// Purpose: timestamps, sequence-numbers and buffers per-motor status samples for the HPS.
// Latency: a qualified sample lands in the FIFO one clock after sample_valid; Avalon reads take two cycles.
// Backpressure: none towards the sampler. Samples arriving with the FIFO full are dropped and counted.
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   sample_*              status sample from the control stage (sample_valid is a 1-cycle pulse)
//   address/read/write/writedata/readdata/waitrequest   Avalon-MM slave, word addressed
//   irq                   FIFO fill-threshold interrupt
// Optional feature: define MYO_STATUS_LOGGER_IRQ_EN to build the irq_threshold register and irq
// output. Without it, irq is tied low and address 8 behaves as an unmapped address.
//
// Register map (word address):
//   0..3  head entry word0..3 (reading 3 pops the head); 0xDEADBEEF when empty
//   4     fill level          5  overflow_count
//   6     {31'b0, enable}; write bit0=enable, bit1=flush
//   7     motor_mask          8  irq_threshold (IRQ build only)
module myo_status_logger #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int FIFO_DEPTH       = 64,
  parameter int CLOCK_SPEED_HZ   = 50_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [7:0]  sample_motor,
  input  logic [31:0] sample_position,
  input  logic [15:0] sample_velocity,
  input  logic [15:0] sample_current,
  input  logic [15:0] sample_displacement,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        irq
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int PRESCALE = CLOCK_SPEED_HZ / 1_000_000;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [7:0]    NUM_MOTORS_B = 8'(NUMBER_OF_MOTORS);
  localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PRESC_LAST   = PW'(PRESCALE - 1);
  localparam logic [31:0]   BAD_WORD     = 32'hDEADBEEF;

  // ---------------------------------------------------------------------------
  // Microsecond timestamp: free-running, independent of enable.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] prescaler;
  logic [31:0]   timestamp;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      timestamp <= '0;
    end else if (prescaler == PRESC_LAST) begin
      prescaler <= '0;
      timestamp <= timestamp + 32'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers and bus decode
  // ---------------------------------------------------------------------------
  logic                        enable;
  logic [NUMBER_OF_MOTORS-1:0] motor_mask;
  logic [7:0]                  seq;
  logic [31:0]                 overflow_count;
  logic                        ctrl_wr;
  logic                        flush;

  assign ctrl_wr = write && (address == 4'd6);
  assign flush   = ctrl_wr && writedata[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enable     <= 1'b0;
      motor_mask <= '1;
    end else begin
      if (ctrl_wr) begin
        enable <= writedata[0];
      end
      if (write && (address == 4'd7)) begin
        motor_mask <= writedata[NUMBER_OF_MOTORS-1:0];
      end
    end
  end

  // Some writedata bits are never decoded; fold them here so the intent is explicit.
  logic unused_bits;
  assign unused_bits = ^writedata;

  // ---------------------------------------------------------------------------
  // Sample qualification and capture stage
  // ---------------------------------------------------------------------------
  // Mask widened to the full 8-bit index range so out-of-range motors index zeros.
  logic [255:0] mask_ext;
  logic         qualified;

  assign mask_ext  = {{(256 - NUMBER_OF_MOTORS){1'b0}}, motor_mask};
  assign qualified = sample_valid && enable &&
                     (sample_motor < NUM_MOTORS_B) && mask_ext[sample_motor];

  logic         cap_vld;
  logic [127:0] cap_entry;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_vld   <= 1'b0;
      cap_entry <= '0;
      seq       <= '0;
    end else begin
      // A sample coinciding with a flush belongs to the discarded epoch.
      cap_vld <= qualified && !flush;
      if (qualified) begin
        cap_entry <= {sample_displacement, sample_motor, seq,
                      sample_velocity, sample_current,
                      sample_position, timestamp};
      end
      // seq advances on every qualified sample, dropped or not, so gaps are visible.
      if (flush) begin
        seq <= '0;
      end else if (qualified) begin
        seq <= seq + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Avalon read handshake: first cycle stalls and registers data, second completes.
  // ---------------------------------------------------------------------------
  logic rd_phase;
  logic rd_first;
  logic rd_done;
  logic pop_armed;

  assign rd_first    = read && !rd_phase;
  assign rd_done     = read && rd_phase;
  assign waitrequest = rd_first;

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [127:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [127:0]  head_entry;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign head_entry = mem[rd_ptr];

  // The pop is armed only if the entry was present when its data was latched,
  // so a pop never removes an entry the host did not see.
  assign pop  = rd_done && pop_armed && !fifo_empty && !flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push = cap_vld && !flush && (!fifo_full || pop);
  assign drop = cap_vld && !flush && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= cap_entry;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow_count <= '0;
    end else if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (drop && (overflow_count != 32'hFFFF_FFFF)) begin
        overflow_count <= overflow_count + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional threshold interrupt
  // ---------------------------------------------------------------------------
`ifdef MYO_STATUS_LOGGER_IRQ_EN
  logic [CW-1:0] irq_threshold;
  logic          irq_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_threshold <= '0;
      irq_q         <= 1'b0;
    end else begin
      if (write && (address == 4'd8)) begin
        irq_threshold <= writedata[CW-1:0];
      end
      // Level-style: follows the fill level, so only draining clears it.
      irq_q <= (irq_threshold != '0) && (count >= irq_threshold);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read data mux and registered readdata
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = BAD_WORD;
    case (address)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        if (!fifo_empty) begin
          rd_mux = head_entry[{address[1:0], 5'd0} +: 32];
        end
      end
      4'd4: rd_mux = 32'(count);
      4'd5: rd_mux = overflow_count;
      4'd6: rd_mux = {31'b0, enable};
      4'd7: rd_mux = 32'(motor_mask);
`ifdef MYO_STATUS_LOGGER_IRQ_EN
      4'd8: rd_mux = 32'(irq_threshold);
`endif
      default: rd_mux = BAD_WORD;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_phase  <= 1'b0;
      pop_armed <= 1'b0;
      readdata  <= '0;
    end else begin
      rd_phase <= rd_first;
      if (rd_first) begin
        readdata  <= rd_mux;
        pop_armed <= (address == 4'd3) && !fifo_empty;
      end
    end
  end

endmodule

// File: tb/tb_myo_status_logger.sv
// Scoreboard bench for myo_status_logger: stimulus tasks update a queue-based
// reference model and enqueue expected read data; a monitor compares each
// completed Avalon read against the queue.
module tb_myo_status_logger;

  localparam int N      = 6;
  localparam int DEPTH  = 64;
  localparam int CLK_HZ = 50_000_000;
  localparam int P      = CLK_HZ / 1_000_000;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  sample_motor = '0;
  logic [31:0] sample_position = '0;
  logic [15:0] sample_velocity = '0;
  logic [15:0] sample_current = '0;
  logic [15:0] sample_displacement = '0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        irq;

  myo_status_logger #(
    .NUMBER_OF_MOTORS(N),
    .FIFO_DEPTH(DEPTH),
    .CLOCK_SPEED_HZ(CLK_HZ)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .sample_valid(sample_valid),
    .sample_motor(sample_motor),
    .sample_position(sample_position),
    .sample_velocity(sample_velocity),
    .sample_current(sample_current),
    .sample_displacement(sample_displacement),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .waitrequest(waitrequest),
    .irq(irq)
  );

  always #10 clock = ~clock;

  // Clock edges seen since reset release; the µs timestamp is cyc / P.
  longint cyc = 0;
  always @(posedge clock) if (reset_n) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // Reference model state
  typedef logic [3:0][31:0] entry_t;   // [0]=timestamp .. [3]=disp/motor/seq
  entry_t      mq[$];
  logic [31:0] m_ovf = '0;
  logic [7:0]  m_seq = '0;
  logic        m_en = 1'b0;
  logic [N-1:0] m_mask = '1;
  int          m_thr = 0;

  // Scoreboard
  logic [31:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clock) begin
    if (reset_n && read && !waitrequest) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_read: got %h expected no read", readdata);
      end else begin
        check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0, 4'd1, 4'd2, 4'd3: return (mq.size() > 0) ? mq[0][a[1:0]] : BAD;
      4'd4: return 32'(mq.size());
      4'd5: return m_ovf;
      4'd6: return {31'b0, m_en};
      4'd7: return 32'(m_mask);
`ifdef MYO_STATUS_LOGGER_IRQ_EN
      4'd8: return 32'(m_thr);
`endif
      default: return BAD;
    endcase
  endfunction

  function automatic void m_sample(input logic [7:0] mot, input logic [31:0] pos,
                                   input logic [15:0] vel, input logic [15:0] cur,
                                   input logic [15:0] disp);
    entry_t e;
    if (!m_en || mot >= N) return;
    if (!m_mask[mot[2:0]]) return;
    e[0] = 32'(cyc / P);
    e[1] = pos;
    e[2] = {vel, cur};
    e[3] = {disp, mot, m_seq};
    if (mq.size() < DEPTH) mq.push_back(e);
    else if (m_ovf != 32'hFFFF_FFFF) m_ovf = m_ovf + 1;
    m_seq = m_seq + 8'd1;
  endfunction

  // All tasks start and end one time unit after a rising edge.
  task automatic avm_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
    address = a;
    read = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    if (a == 4'd3 && mq.size() > 0) mq.delete(0);
    #1;
    check({nm, "_waitreq"}, {31'b0, waitrequest}, 32'd1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    read = 1'b0;
  endtask

  task automatic rd_m(input logic [3:0] a, input string nm);
    avm_read(a, m_read(a), nm);
  endtask

  task automatic avm_write(input logic [3:0] a, input logic [31:0] d);
    address = a;
    write = 1'b1;
    writedata = d;
    if (a == 4'd6) begin
      m_en = d[0];
      if (d[1]) begin
        mq.delete();
        m_ovf = '0;
        m_seq = '0;
      end
    end else if (a == 4'd7) begin
      m_mask = d[N-1:0];
    end
`ifdef MYO_STATUS_LOGGER_IRQ_EN
    else if (a == 4'd8) begin
      m_thr = int'(d[6:0]);
    end
`endif
    @(posedge clock); #1;
    write = 1'b0;
  endtask

  task automatic set_sample(input logic [7:0] mot, input logic [31:0] pos,
                            input logic [15:0] vel, input logic [15:0] cur,
                            input logic [15:0] disp);
    sample_motor = mot;
    sample_position = pos;
    sample_velocity = vel;
    sample_current = cur;
    sample_displacement = disp;
    sample_valid = 1'b1;
    m_sample(mot, pos, vel, cur, disp);
  endtask

  task automatic drive_sample(input logic [7:0] mot, input logic [31:0] pos,
                              input logic [15:0] vel, input logic [15:0] cur,
                              input logic [15:0] disp);
    set_sample(mot, pos, vel, cur, disp);
    @(posedge clock); #1;
    sample_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic rand_sample(input logic [7:0] mot);
    drive_sample(mot, $urandom, 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  // Pop the head via word3 while a new sample arrives on the completing cycle.
  task automatic pop_with_sample(input string nm);
    address = 4'd3;
    read = 1'b1;
    exp_q.push_back(m_read(4'd3));
    name_q.push_back(nm);
    if (mq.size() > 0) mq.delete(0);
    @(posedge clock); #1;
    set_sample(8'd1, 32'hCAFE_0001, 16'd7, 16'd8, 16'h0BEE);
    @(posedge clock); #1;
    read = 1'b0;
    sample_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic check_irq(input string nm, input logic exp);
    @(posedge clock); #1;
    check(nm, {31'b0, irq}, {31'b0, exp});
  endtask

  localparam logic IRQ_ON =
`ifdef MYO_STATUS_LOGGER_IRQ_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Reset state
    check("rst_readdata", readdata, 32'd0);
    check("rst_waitreq", {31'b0, waitrequest}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    avm_read(4'd4, 32'd0, "rst_fill");
    avm_read(4'd5, 32'd0, "rst_ovf");
    avm_read(4'd6, 32'd0, "rst_enable");
    avm_read(4'd7, 32'h3F, "rst_mask");
    avm_read(4'd0, BAD, "rst_empty_w0");
    avm_read(4'd9, BAD, "rst_unmapped");

    // Single sample round trip
    avm_write(4'd6, 32'd1);
    drive_sample(8'd2, 32'h12345678, -16'sd5, 16'd300, 16'h0040);
    avm_read(4'd4, 32'd1, "t1_fill");
    rd_m(4'd0, "t1_w0_ts");
    avm_read(4'd1, 32'h12345678, "t1_w1");
    avm_read(4'd2, 32'hFFFB012C, "t1_w2");
    avm_read(4'd3, 32'h00400200, "t1_w3");
    avm_read(4'd4, 32'd0, "t1_fill_after");

    // Overflow: 70 samples into a 64-deep FIFO
    avm_write(4'd6, 32'd3);
    for (int i = 0; i < 70; i++) drive_sample(8'd1, 32'(i), 16'd0, 16'd0, 16'(i));
    avm_read(4'd4, 32'd64, "t2_fill");
    avm_read(4'd5, 32'd6, "t2_ovf");
    for (int i = 0; i < 63; i++) begin
      rd_m(4'd0, "t2_drain_w0");
      rd_m(4'd3, "t2_drain_w3");
    end
    avm_read(4'd3, 32'h003F013F, "t2_64th_seq63");
    drive_sample(8'd1, 32'd0, 16'd0, 16'd0, 16'h0AAA);
    avm_read(4'd3, 32'h0AAA0146, "t2_next_seq70");

    // Motor mask filtering
    avm_write(4'd6, 32'd3);
    avm_write(4'd7, 32'b000101);
    for (int m = 0; m < 6; m++) rand_sample(8'(m));
    rand_sample(8'd9);
    avm_read(4'd4, 32'd2, "t3_fill");
    rd_m(4'd1, "t3_e0_w1");
    rd_m(4'd3, "t3_e0_w3");
    rd_m(4'd3, "t3_e1_w3");
    drive_sample(8'd2, 32'd0, 16'd0, 16'd0, 16'd0);
    avm_read(4'd3, 32'h00000202, "t3_seq2");
    avm_write(4'd7, 32'h3F);

    // Full FIFO, pop coinciding with a sample: no drop
    avm_write(4'd6, 32'd3);
    for (int i = 0; i < 64; i++) rand_sample(8'(i % N));
    pop_with_sample("t4_pop_w3");
    avm_read(4'd4, 32'd64, "t4_fill");
    avm_read(4'd5, 32'd0, "t4_ovf");

    // Flush with 10 entries and overflow 4
    for (int i = 0; i < 4; i++) rand_sample(8'd0);
    avm_read(4'd5, 32'd4, "t5_ovf4");
    for (int i = 0; i < 54; i++) rd_m(4'd3, "t5_drain_w3");
    avm_read(4'd4, 32'd10, "t5_fill10");
    avm_write(4'd6, 32'd3);
    avm_read(4'd4, 32'd0, "t5_fill0");
    avm_read(4'd5, 32'd0, "t5_ovf0");
    avm_read(4'd6, 32'd1, "t5_enable");
    avm_read(4'd0, BAD, "t5_empty");

    // Threshold interrupt
    avm_write(4'd8, 32'd8);
    avm_read(4'd8, IRQ_ON ? 32'd8 : BAD, "t6_thr");
    for (int i = 0; i < 7; i++) rand_sample(8'd3);
    check_irq("t6_irq_below", 1'b0);
    rand_sample(8'd3);
    check_irq("t6_irq_at", IRQ_ON);
    avm_read(4'd4, 32'd8, "t6_fill");
    check_irq("t6_irq_after_fill_read", IRQ_ON);
    rd_m(4'd3, "t6_pop");
    check_irq("t6_irq_drained", 1'b0);
    avm_write(4'd8, 32'd0);

    // Randomized mix against the model
    avm_write(4'd6, 32'd3);
    for (int it = 0; it < 600; it++) begin
      int op;
      op = $urandom_range(0, 11);
      if (op <= 4) begin
        rand_sample(8'($urandom_range(0, 9)));
      end else if (op <= 8) begin
        rd_m(4'($urandom_range(0, 10)), "rnd_read");
      end else if (op == 9) begin
        avm_write(4'd7, ($urandom_range(0, 3) == 0) ? $urandom : 32'h3F);
      end else if (op == 10) begin
        avm_write(4'd6, {30'b0, ($urandom_range(0, 15) == 0),
                         ($urandom_range(0, 4) != 0)});
      end else begin
        avm_write(4'($urandom_range(8, 9)), $urandom & 32'h7F);
        check_irq("rnd_irq", IRQ_ON && m_thr != 0 && mq.size() >= m_thr);
      end
    end
    rd_m(4'd4, "rnd_final_fill");
    rd_m(4'd5, "rnd_final_ovf");
    @(posedge clock); #1;

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
